// File: rtl/irrigation_matrix_scanner_pkg.sv
// Shared status codes, matrix geometry and the glyph art for the irrigation matrix scanner.
package irrigation_matrix_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_IRRIGATING = 2'd1,
    ST_TANK_LOW   = 2'd2,
    ST_FAULT      = 2'd3
  } status_e;

  localparam int unsigned MATRIX_ROWS = 7;
  localparam int unsigned MAX_COLS    = 16;
  localparam int unsigned GLYPH_COLS  = 5;

  // Art is packed {col4, col3, col2, col1, col0}; bit 0 of each column is the top row.
  function automatic logic [MATRIX_ROWS-1:0] glyph(input status_e status, input logic [3:0] col);
    logic [GLYPH_COLS*MATRIX_ROWS-1:0] art;
    logic [MATRIX_ROWS-1:0]            pat;
    case (status)
      ST_IDLE:       art = {7'h3E, 7'h41, 7'h41, 7'h41, 7'h3E};
      ST_IRRIGATING: art = {7'h0C, 7'h1E, 7'h3F, 7'h1E, 7'h0C};
      ST_TANK_LOW:   art = {7'h7C, 7'h78, 7'h70, 7'h60, 7'h40};
      default:       art = {7'h63, 7'h14, 7'h08, 7'h14, 7'h63};
    endcase
    case (col)
      4'd0:    pat = art[6:0];
      4'd1:    pat = art[13:7];
      4'd2:    pat = art[20:14];
      4'd3:    pat = art[27:21];
      4'd4:    pat = art[34:28];
      default: pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/irrigation_matrix_scanner_if.sv
// Controller-to-matrix signal bundle; master is the scanner side.
interface irrigation_matrix_scanner_if #(
  parameter int unsigned N_COLS   = 5,
  parameter int unsigned N_ROWS   = 7,
  parameter int unsigned STATUS_W = 2
);
  logic                enable;
  logic [STATUS_W-1:0] irrigation_status;
  logic [N_COLS-1:0]   col_sel;
  logic [N_ROWS-1:0]   row_data;
  logic                frame_done;
  logic [STATUS_W-1:0] status_shown;

  modport master (
    input  enable, irrigation_status,
    output col_sel, row_data, frame_done, status_shown
  );

  modport slave (
    output enable, irrigation_status,
    input  col_sel, row_data, frame_done, status_shown
  );
endinterface

// File: rtl/irrigation_matrix_scanner_glyph_rom.sv
// Combinational glyph lookup: (status, column) -> row pattern; columns past the art read as blank.
module irrigation_glyph_rom
  import irrigation_matrix_pkg::*;
(
  input  status_e                status,
  input  logic [3:0]             col_idx,
  output logic [MATRIX_ROWS-1:0] pattern
);
  always_comb begin
    pattern = glyph(status, col_idx);
  end
endmodule

// File: rtl/irrigation_matrix_scanner.sv
// Time-multiplexed LED matrix scanner with per-frame status latch and slot blanking.
// Optional fault blinking is built when IRRIG_BLINK_EN is defined.
module irrigation_matrix_scanner
  import irrigation_matrix_pkg::*;
#(
  parameter int unsigned N_COLS       = 5,
  parameter int unsigned N_ROWS       = 7,
  parameter int unsigned STATUS_W     = 2,
  parameter int unsigned SCAN_DIV     = 1000,
  parameter int unsigned BLANK_CYCLES = 8,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input logic clk,
  input logic reset,
  irrigation_matrix_scanner_if.master bus
);
  localparam int unsigned CW = $clog2(N_COLS);
  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [PW-1:0]          presc;
  logic [CW-1:0]          col_idx;
  logic [STATUS_W-1:0]    shown;
  logic                   slot_end;
  logic                   frame_end;
  logic                   lit;
  logic                   blink_off;
  logic [MATRIX_ROWS-1:0] pattern;
  status_e                shown_st;
  status_e                incoming_st;

  assign shown_st    = status_e'(shown[1:0]);
  assign incoming_st = status_e'(bus.irrigation_status[1:0]);
  assign slot_end    = (presc == PW'(SCAN_DIV - 1));
  assign frame_end   = slot_end && (col_idx == CW'(N_COLS - 1));

  generate
    if (BLANK_CYCLES == 0) begin : g_no_blank
      assign lit = 1'b1;
    end else begin : g_blank
      assign lit = (presc >= PW'(BLANK_CYCLES));
    end
  endgenerate

  irrigation_glyph_rom u_rom (
    .status  (shown_st),
    .col_idx (4'(col_idx)),
    .pattern (pattern)
  );

`ifdef IRRIG_BLINK_EN
  localparam int unsigned BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;

  // Counting starts only once a fault frame is already on display, so the first
  // BLINK_FRAMES fault frames are visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (bus.enable && frame_end) begin
      if (incoming_st != ST_FAULT || shown_st != ST_FAULT) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  assign blink_off = blink_phase && (shown_st == ST_FAULT);
`else
  // BLINK_FRAMES is at least 1, so the fault glyph is never suppressed here.
  assign blink_off = (BLINK_FRAMES == 0);
`endif

  // Outputs are registered from the pre-edge counters; status_shown lags the internal
  // latch by the same cycle so it changes right after the frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc            <= '0;
      col_idx          <= '0;
      shown            <= '0;
      bus.col_sel      <= N_COLS'(1);
      bus.row_data     <= '0;
      bus.frame_done   <= 1'b0;
      bus.status_shown <= '0;
    end else begin
      bus.status_shown <= shown;
      if (bus.enable) begin
        presc <= slot_end ? '0 : presc + 1'b1;
        if (slot_end) begin
          col_idx <= (col_idx == CW'(N_COLS - 1)) ? '0 : col_idx + 1'b1;
        end
        if (frame_end) begin
          shown <= bus.irrigation_status;
        end
        bus.col_sel    <= N_COLS'(1) << col_idx;
        bus.row_data   <= (lit && !blink_off) ? N_ROWS'(pattern) : '0;
        bus.frame_done <= frame_end;
      end else begin
        bus.col_sel    <= '0;
        bus.row_data   <= '0;
        bus.frame_done <= 1'b0;
      end
    end
  end

endmodule
